// File: rtl/txf_pkg.sv
// Shared constants, frame layout offsets and FSM state type for the telemetry frame builder.
package txf_pkg;
    localparam int          PAYLOAD   = 15;
    localparam int          FRAME_LEN = PAYLOAD + 3;
    localparam logic [7:0]  SYNC      = 8'hA5;
    localparam logic [5:0]  GAP       = 6'd63;

    localparam int OFS_SYNC = 0;
    localparam int OFS_CYC  = 1;
    localparam int OFS_PAY  = 2;
    localparam int OFS_CSUM = FRAME_LEN - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SUM     = 3'd1,
        ARM     = 3'd2,
        SEND    = 3'd3,
        RELEASE = 3'd4
    } txf_state_e;
endpackage

// File: rtl/txf_bank.sv
// Two payload banks with a select bit: the active bank is read by the transmitter,
// the shadow bank is written by the host and read by the checksum engine.
module txf_bank
    import txf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_swap,
    input  logic [3:0] i_act_addr,
    output logic [7:0] o_act_data,
    input  logic [3:0] i_shd_addr,
    output logic [7:0] o_shd_data,
    output logic       o_sel
);
    logic [7:0] r_mem [2][PAYLOAD];
    logic       r_sel;
    logic       w_wr_bank;
    logic       w_wr_ok;

    // On the swap edge the outgoing active bank becomes the new shadow, so a write
    // landing then goes there and never disturbs the frame being armed.
    assign w_wr_bank = i_swap ? r_sel : ~r_sel;
    assign w_wr_ok   = i_wr_en && (32'(i_wr_addr) < PAYLOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < PAYLOAD; i++) begin
                    r_mem[b][i] <= 8'h00;
                end
            end
        end else begin
            if (i_swap) begin
                r_sel <= ~r_sel;
            end
            if (w_wr_ok) begin
                r_mem[w_wr_bank][i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_act_data = (32'(i_act_addr) < PAYLOAD) ? r_mem[r_sel][i_act_addr] : 8'h00;
    assign o_shd_data = (32'(i_shd_addr) < PAYLOAD) ? r_mem[~r_sel][i_shd_addr] : 8'h00;
    assign o_sel      = r_sel;
endmodule

// File: rtl/tx_frame_builder.sv
// Double-buffered telemetry frame source for the RS485 transmitter: checksums the shadow
// bank on commit, swaps it active, requests transfer and enforces an inter-frame gap.
module tx_frame_builder
    import txf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic [4:0] tx_addr,
    output logic [7:0] tx_data,
    output logic       rq,
    output logic [4:0] cycle_id,
    output logic       busy,
    output logic       overrun
);
    txf_state_e r_state;
    logic       r_pending;
    logic       r_overrun;
    logic       r_rq;
    logic [4:0] r_cyc;
    logic [3:0] r_idx;
    logic [7:0] r_acc;
    logic [7:0] r_csum [2];
    logic [5:0] r_gap;

    logic       w_sel;
    logic       w_swap;
    logic [3:0] w_act_addr;
    logic [7:0] w_act_data;
    logic [7:0] w_shd_data;
    logic [4:0] w_cyc_next;

    assign w_swap     = (r_state == ARM);
    assign w_act_addr = 4'(tx_addr - 5'(OFS_PAY));
    assign w_cyc_next = r_cyc + 5'd1;

    txf_bank u_bank (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_swap     (w_swap),
        .i_act_addr (w_act_addr),
        .o_act_data (w_act_data),
        .i_shd_addr (r_idx),
        .o_shd_data (w_shd_data),
        .o_sel      (w_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_rq      <= 1'b0;
            r_cyc     <= 5'd0;
            r_idx     <= 4'd0;
            r_acc     <= 8'h00;
            r_csum[0] <= 8'h00;
            r_csum[1] <= 8'h00;
            r_gap     <= 6'd0;
        end else begin
            if (commit && (r_state != IDLE)) begin
                r_pending <= 1'b1;
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (commit || r_pending) begin
                        r_pending <= 1'b0;
                        r_idx     <= 4'd0;
                        // Seed with the header bytes the frame will carry after the swap.
                        r_acc     <= SYNC + {3'b000, w_cyc_next};
                        r_state   <= SUM;
                    end
                end
                SUM: begin
                    r_acc <= r_acc + w_shd_data;
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'(PAYLOAD - 1)) begin
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    r_cyc          <= w_cyc_next;
                    r_csum[~w_sel] <= r_acc;
                    r_rq           <= 1'b1;
                    r_state        <= SEND;
                end
                SEND: begin
                    if (tx_addr == 5'(FRAME_LEN)) begin
                        r_rq    <= 1'b0;
                        r_gap   <= 6'd0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_gap <= r_gap + 6'd1;
                    if (r_gap == GAP - 6'd1) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx_data = 8'hFF;
        if (tx_addr == 5'(OFS_SYNC)) begin
            tx_data = SYNC;
        end else if (tx_addr == 5'(OFS_CYC)) begin
            tx_data = {3'b000, r_cyc};
        end else if (tx_addr < 5'(OFS_CSUM)) begin
            tx_data = w_act_data;
        end else if (tx_addr == 5'(OFS_CSUM)) begin
            tx_data = r_csum[w_sel];
        end
    end

    assign rq       = r_rq;
    assign cycle_id = r_cyc;
    assign busy     = (r_state != IDLE);
    assign overrun  = r_overrun;
endmodule

// File: tb/tb_tx_frame_builder.sv
// Bench for tx_frame_builder: frame-level reference model, per-cycle compare and directed scenarios.
module tb_tx_frame_builder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'h00;
    logic       commit = 1'b0;
    logic [4:0] tx_addr = 5'd0;
    logic [7:0] tx_data;
    logic       rq;
    logic [4:0] cycle_id;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;
    bit tx_auto = 1'b0;

    tx_frame_builder dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit   (commit),
        .tx_addr  (tx_addr),
        .tx_data  (tx_data),
        .rq       (rq),
        .cycle_id (cycle_id),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: frames as snapshots + plain sums, timing as countdowns.
    // phase 0 idle, 1 building (16 edges to rq), 2 sending, 3 gap (63 edges)
    logic [7:0] m_bank [2][15];
    logic [7:0] m_snap [15];
    logic [7:0] m_csum [2];
    logic [4:0] m_cyc;
    int         m_act, m_phase, m_cnt, m_sum;
    bit         m_pending, m_overrun, m_rq;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 15; i++) m_bank[b][i] = 8'h00;
                m_csum[b] = 8'h00;
            end
            m_cyc = 5'd0; m_act = 0; m_phase = 0; m_cnt = 0;
            m_pending = 1'b0; m_overrun = 1'b0; m_rq = 1'b0;
        end else begin
            if (wr_en && int'(wr_addr) < 15) m_bank[1 - m_act][wr_addr] = wr_data;
            if (m_phase != 0 && commit) begin
                if (m_pending) m_overrun = 1'b1;
                m_pending = 1'b1;
            end
            case (m_phase)
                0: if (commit || m_pending) begin
                    m_pending = 1'b0;
                    for (int i = 0; i < 15; i++) m_snap[i] = m_bank[1 - m_act][i];
                    m_cnt = 16;
                    m_phase = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_cyc = m_cyc + 5'd1;
                        m_sum = 32'hA5 + int'(m_cyc);
                        for (int i = 0; i < 15; i++) m_sum += int'(m_snap[i]);
                        m_act = 1 - m_act;
                        m_csum[m_act] = m_sum[7:0];
                        m_rq = 1'b1;
                        m_phase = 2;
                    end
                end
                2: if (tx_addr == 5'd18) begin
                    m_rq = 1'b0;
                    m_cnt = 63;
                    m_phase = 3;
                end
                default: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 0;
                end
            endcase
        end
    end

    function automatic logic [7:0] exp_byte(input logic [4:0] a);
        if (a == 5'd0) return 8'hA5;
        if (a == 5'd1) return {3'b000, m_cyc};
        if (a <= 5'd16) return m_bank[m_act][int'(a) - 2];
        if (a == 5'd17) return m_csum[m_act];
        return 8'hFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cmp_rq", 32'(rq), 32'(m_rq));
            chk("cmp_busy", 32'(busy), 32'(m_phase != 0));
            chk("cmp_cycle_id", 32'(cycle_id), 32'(m_cyc));
            chk("cmp_overrun", 32'(overrun), 32'(m_overrun));
            chk("cmp_tx_data", 32'(tx_data), 32'(exp_byte(tx_addr)));
        end
    end

    // Model transmitter: steps tx_addr while rq is high, parks at 0 otherwise.
    always @(posedge clk) begin
        #1;
        if (tx_auto) begin
            if (rq) begin
                if (tx_addr != 5'd18) tx_addr = tx_addr + 5'd1;
            end else begin
                tx_addr = 5'd0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic wait_rq(input logic lvl, input int max, input string nm);
        int n = 0;
        while (rq !== lvl && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (rq !== lvl) begin
            errors++;
            $display("FAIL %s_timeout actual=%b required=%b", nm, rq, lvl);
        end
    endtask

    task automatic read_at(input logic [4:0] a, input logic [7:0] lit, input string nm);
        tx_addr = a;
        @(negedge clk);
        #1;
        chk(nm, 32'(tx_data), 32'(lit));
    endtask

    initial begin
        int n, bl, hi;
        logic [7:0] lit;
        #200_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bl, hi;
        logic [7:0] lit;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        run_cmp = 1'b1;

        // reset state
        chk("rst_rq", 32'(rq), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_cycle_id", 32'(cycle_id), 0);
        read_at(5'd17, 8'h00, "rst_csum");
        read_at(5'd18, 8'hFF, "oob_18");
        read_at(5'd25, 8'hFF, "oob_25");
        read_at(5'd31, 8'hFF, "oob_31");
        tx_addr = 5'd0;
        tick();

        // test 1: payload 01..0F, last write on the commit clock
        for (int i = 0; i < 14; i++) write_byte(4'(i), 8'(i + 1));
        write_byte(4'd15, 8'h77);
        wr_en = 1'b1; wr_addr = 4'd14; wr_data = 8'h0F; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        n = 1;
        while (!rq && n < 40) begin
            tick();
            n++;
        end
        chk("t1_latency", 32'(n), 17);
        for (int a = 0; a < 18; a++) begin
            lit = (a == 0) ? 8'hA5 : (a == 1) ? 8'h01 : (a <= 16) ? 8'(a - 1) : 8'h1E;
            read_at(5'(a), lit, "t1_byte");
        end

        // test 4 and 3: shadow writes and double commit during SEND
        write_byte(4'd0, 8'hEE);
        read_at(5'd2, 8'h01, "t4_active_unchanged");
        for (int i = 1; i < 15; i++) write_byte(4'(i), 8'($urandom_range(0, 255)));
        pulse_commit();
        chk("t3_no_overrun_yet", 32'(overrun), 0);
        pulse_commit();
        chk("t3_overrun", 32'(overrun), 1);
        read_at(5'd2, 8'h01, "t4_still_unchanged");

        // test 2: transmit, then measure gap and idle window
        tx_addr = 5'd0;
        tx_auto = 1'b1;
        wait_rq(1'b0, 40, "t2_fall");
        n = 0; bl = 0;
        while (!rq && n < 200) begin
            if (!busy) bl++;
            if (n == 5) begin
                tx_auto = 1'b0;
                tx_addr = 5'd0;
            end
            tick();
            n++;
        end
        chk("t2_rq_low_clocks", 32'(n), 80);
        chk("t2_busy_low_clocks", 32'(bl), 1);
        chk("t3_cycle_id", 32'(cycle_id), 2);
        read_at(5'd2, 8'hEE, "t3_new_byte0");
        tx_addr = 5'd0;
        tx_auto = 1'b1;

        // test 5: 33 back-to-back frames with random payloads
        for (int f = 0; f < 33; f++) begin
            for (int i = 0; i < 15; i++)
                write_byte(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            pulse_commit();
            wait_rq(1'b0, 40, "t5_fall");
            wait_rq(1'b1, 200, "t5_rise");
        end
        chk("t5_wrapped_cycle_id", 32'(cycle_id), (2 + 33) % 32);

        // test 6: reset mid-SEND at tx_addr 7
        n = 0;
        while (!(rq && tx_addr == 5'd7) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_addr7", 32'(tx_addr), 7);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rq_async", 32'(rq), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_cycle_id", 32'(cycle_id), 0);
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b0;
        hi = 0;
        repeat (100) begin
            tick();
            if (rq) hi++;
        end
        chk("t6_no_resend", 32'(hi), 0);
        chk("t6_overrun_cleared", 32'(overrun), 0);

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
